// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the bit-serial arithmetic blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_arith_pkg;

   // Default operand width for the serial datapaths.
   localparam int SER_W_DEF = 4;

   // Sequencer states shared by the serial arithmetic units.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } ser_state_t;

endpackage

// File: rtl/fs_cell.sv
// Full-subtractor bit cell: d = a - b - bi for one bit, with borrow out.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a (minuend bit), b (subtrahend bit), bi (borrow in),
//        d (difference bit), bo (borrow out).
module fs_cell (
   input  logic a,
   input  logic b,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = a ^ b ^ bi;
   // Borrow when the minuend bit cannot cover the subtrahend plus incoming borrow.
   assign bo = (~a & b) | (~a & bi) | (b & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = (a - b - bin) mod 2^W, LSB first, one bit per clock.
// Latency: start accepted at edge E0, done pulses in the cycle after edge E0+W; one op per W+2 cycles.
// Backpressure: none; start is only sampled in IDLE and is ignored while busy (no queuing).
// Ports: clk, rst (async active-high), start, a, b, bin in;
//        busy, done, diff, bout out; ovf out only when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int W = SER_W_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] diff,
   output logic         bout
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic         ovf
`endif
);

   // Wide enough to hold W without wrapping, for any W >= 1.
   localparam int CW = $clog2(W + 1);

   ser_state_t    state;
   ser_state_t    state_nxt;

   logic [W-1:0]  a_sr;
   logic [W-1:0]  b_sr;
   logic [W-1:0]  res;
   logic [W-1:0]  res_nxt;
   logic          borrow;
   logic [CW-1:0] cnt;
   logic          d_bit;
   logic          bo_bit;
   logic          last;

   fs_cell u_fs_cell (
      .a  (a_sr[0]),
      .b  (b_sr[0]),
      .bi (borrow),
      .d  (d_bit),
      .bo (bo_bit)
   );

   assign last = (cnt == CW'(W - 1));

   // New difference bit enters at the MSB; after W shifts bit 0 lands at the LSB.
   // Written as shift/or so it stays legal for W = 1.
   assign res_nxt = (W'(d_bit) << (W - 1)) | (res >> 1);

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            busy      = 1'b1;
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res    <= '0;
         borrow <= 1'b0;
         cnt    <= '0;
         diff   <= '0;
         bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr   <= a;
                  b_sr   <= b;
                  borrow <= bin;
                  cnt    <= '0;
                  res    <= '0;
               end
            end
            RUN: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               borrow <= bo_bit;
               cnt    <= cnt + CW'(1);
               res    <= res_nxt;
               // Visible result only moves on the completing edge, never mid-operation.
               if (last) begin
                  diff <= res_nxt;
                  bout <= bo_bit;
`ifdef SERIAL_SUB_OVF_EN
                  // Signed overflow: borrow into the MSB differs from borrow out of it.
                  ovf  <= borrow ^ bo_bit;
`endif
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int total = 0;
   int bad   = 0;

   // Last result the DUT should be holding (for checking that it never shows partial values).
   logic [W-1:0] held_diff = '0;
   logic         held_bout = 1'b0;

   serial_subtractor #(.W(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf   (ovf)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operand values.
   function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mbin,
                                 output logic [W-1:0] md, output logic mbo, output logic mov);
      int ua, ub, r, sa, sb, sr;
      logic [31:0] rv;
      ua = int'(ma);
      ub = int'(mb);
      r  = ua - ub - int'(mbin);
      rv = r;
      md  = rv[W-1:0];
      mbo = (r < 0);
      sa = ma[W-1] ? ua - (1 << W) : ua;
      sb = mb[W-1] ? ub - (1 << W) : ub;
      sr = sa - sb - int'(mbin);
      mov = (sr < -(1 << (W-1))) || (sr > (1 << (W-1)) - 1);
   endfunction

   // One complete operation with latency, hold and result checks. Starts and ends at a negedge.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin);
      logic [W-1:0] ed;
      logic         eb, eo;
      int           n;
      model(ta, tb, tbin, ed, eb, eo);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      // Scramble inputs: operands must have been captured at the start edge.
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      check("busy_run", 32'(busy), 32'd1);
      check("done_early", 32'(done), 32'd0);
      n = 0;
      while (!done && n < W + 3) begin
         check("diff_hold_run", 32'(diff), 32'(held_diff));
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(W));
      check("diff", 32'(diff), 32'(ed));
      check("bout", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
      check("ovf", 32'(ovf), 32'(eo));
`endif
      check("busy_done", 32'(busy), 32'd1);
      held_diff = ed;
      held_bout = eb;
      @(posedge clk);
      @(negedge clk);
      check("done_pulse_end", 32'(done), 32'd0);
      check("busy_idle", 32'(busy), 32'd0);
      check("diff_hold_idle", 32'(diff), 32'(held_diff));
      check("bout_hold_idle", 32'(bout), 32'(held_bout));
   endtask

   initial begin
      int pulses, first_pulse, last_pulse;
      logic [W-1:0] ed;
      logic         eb, eo;

      // Reset state.
      rst = 1'b1;
      #12;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Directed vectors.
      do_op(4'b0011, 4'b0101, 1'b0);
      do_op(4'b1111, 4'b0001, 1'b0);
      do_op(4'b1010, 4'b0101, 1'b1);
      do_op(4'b0000, 4'b0000, 1'b1);
      do_op(4'b1000, 4'b0001, 1'b0);
      do_op(4'b0111, 4'b1111, 1'b1);

      // Randomized operands.
      for (int i = 0; i < 40; i++) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      // start pulsed during RUN must be ignored.
      a = 4'b0011; b = 4'b0101; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      a = 4'b1111; b = 4'b0000; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         if (done) begin
            pulses++;
            check("ign_diff", 32'(diff), 32'b1110);
            check("ign_bout", 32'(bout), 32'd1);
         end
         @(negedge clk);
      end
      check("ign_pulses", 32'(pulses), 32'd1);
      check("ign_idle", 32'(busy), 32'd0);
      held_diff = 4'b1110;
      held_bout = 1'b1;

      // Asynchronous reset two cycles into RUN.
      a = 4'b1001; b = 4'b0010; bin = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_diff", 32'(diff), 32'd0);
      check("arst_bout", 32'(bout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      held_diff = '0;
      held_bout = 1'b0;
      @(negedge clk);
      do_op(4'b0110, 4'b0010, 1'b0);

      // start held high for 20 edges: back-to-back ops every W+2 cycles.
      model(4'b0101, 4'b0011, 1'b0, ed, eb, eo);
      a = 4'b0101; b = 4'b0011; bin = 1'b0; start = 1'b1;
      pulses = 0;
      first_pulse = -1;
      last_pulse = -1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            pulses++;
            check("hold_diff", 32'(diff), 32'(ed));
            check("hold_bout", 32'(bout), 32'(eb));
            if (last_pulse >= 0) check("hold_period", 32'(k - last_pulse), 32'(W + 2));
            else first_pulse = k;
            last_pulse = k;
         end
      end
      start = 1'b0;
      check("hold_first", 32'(first_pulse), 32'(W));
      check("hold_pulses", 32'(pulses), 32'd3);
      // Drain the op accepted just before start dropped.
      for (int k = 0; k < W + 4 && busy; k++) @(negedge clk);
      check("hold_drain", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule
